// File: rtl/regfile_scoreboard.sv
// Multi-port register file with a per-register busy scoreboard. Register 0 is hardwired to zero.
// Reads are combinational, with optional same-cycle forwarding from active write ports.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*XLEN-1:0]   wr_data,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  output logic [NREGS-1:0]      busy_vec,
  output logic [NREGS*XLEN-1:0] dbg_regs
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [XLEN-1:0]  rdat_s [NRD];
  logic             rbsy_s [NRD];

  // A write forwards only to a real, nonzero register, so out-of-range and x0 reads stay zero.
  function automatic logic fwd_hit(input logic en, input logic [AW-1:0] wa,
                                   input logic [AW-1:0] ra);
    return (BYPASS != 0) && en && (wa == ra) && (ra != {AW{1'b0}}) &&
           (int'(ra) < NREGS);
  endfunction

  // Next-state: later write ports overwrite earlier ones; an issue overrides a same-cycle clear.
  always_comb begin
    regs_d    = regs_q;
    busy_d    = busy_q;
    regs_d[0] = {XLEN{1'b0}};
    busy_d[0] = 1'b0;
    for (int n = 1; n < NREGS; n++) begin
      for (int j = 0; j < NWR; j++) begin
        regs_d[n] = (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(n))) ?
                    wr_data[j*XLEN +: XLEN] : regs_d[n];
        busy_d[n] = (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(n))) ? 1'b0 : busy_d[n];
      end
      busy_d[n] = busy_d[n] | (iss_valid & (iss_rd == AW'(n)));
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int n = 0; n < NREGS; n++) begin
        regs_q[n] <= {XLEN{1'b0}};
      end
      busy_q <= {NREGS{1'b0}};
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read ports: a decoded lookup that yields zero for unmatched addresses, then forwarding.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rdat_s[i] = {XLEN{1'b0}};
      rbsy_s[i] = 1'b0;
      for (int n = 0; n < NREGS; n++) begin
        rdat_s[i] = (rd_addr[i*AW +: AW] == AW'(n)) ? regs_q[n] : rdat_s[i];
        rbsy_s[i] = (rd_addr[i*AW +: AW] == AW'(n)) ? busy_q[n] : rbsy_s[i];
      end
      for (int j = 0; j < NWR; j++) begin
        rdat_s[i] = fwd_hit(wr_en[j], wr_addr[j*AW +: AW], rd_addr[i*AW +: AW]) ?
                    wr_data[j*XLEN +: XLEN] : rdat_s[i];
        rbsy_s[i] = fwd_hit(wr_en[j], wr_addr[j*AW +: AW], rd_addr[i*AW +: AW]) ?
                    1'b0 : rbsy_s[i];
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    assign rd_data[i*XLEN +: XLEN] = rdat_s[i];
    assign rd_busy[i]              = rbsy_s[i];
  end

  for (genvar n = 0; n < NREGS; n++) begin : g_dbg
    assign dbg_regs[n*XLEN +: XLEN] = regs_q[n];
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two instances (32 regs with forwarding, 24 regs without) on
// shared stimulus, checked every cycle against an array model plus directed literal checks.
module tb_regfile_scoreboard;
  localparam int XLEN = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;
  localparam int NR0  = 32;
  localparam int NR1  = 24;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NRD*AW-1:0]     rd_addr;
  logic [NWR-1:0]        wr_en;
  logic [NWR*AW-1:0]     wr_addr;
  logic [NWR*XLEN-1:0]   wr_data;
  logic                  iss_valid;
  logic [AW-1:0]         iss_rd;
  logic [NRD*XLEN-1:0]   rd_data0, rd_data1;
  logic [NRD-1:0]        rd_busy0, rd_busy1;
  logic [NR0-1:0]        busy_vec0;
  logic [NR1-1:0]        busy_vec1;
  logic [NR0*XLEN-1:0]   dbg0;
  logic [NR1*XLEN-1:0]   dbg1;

  logic [31:0] m_regs [2][32];
  logic        m_busy [2][32];
  int          n_chk = 0;
  int          n_fail = 0;
  bit          check_en = 1'b0;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NR0), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut0 (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .busy_vec(busy_vec0), .dbg_regs(dbg0));

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NR1), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut1 (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .busy_vec(busy_vec1), .dbg_regs(dbg1));

  always #5 clk = ~clk;

  function automatic int nregs(input int k);
    return (k == 0) ? NR0 : NR1;
  endfunction

  function automatic bit byp(input int k);
    return (k == 0);
  endfunction

  function automatic logic [31:0] exp_data(input int k, input int i);
    int a;
    logic [31:0] v;
    a = int'(rd_addr[i*AW +: AW]);
    if (a == 0 || a >= nregs(k)) return 32'h0;
    v = m_regs[k][a];
    if (byp(k)) begin
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) v = wr_data[j*XLEN +: XLEN];
    end
    return v;
  endfunction

  function automatic logic exp_busy(input int k, input int i);
    int a;
    logic b;
    a = int'(rd_addr[i*AW +: AW]);
    if (a == 0 || a >= nregs(k)) return 1'b0;
    b = m_busy[k][a];
    if (byp(k)) begin
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) b = 1'b0;
    end
    return b;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, idx, $time, act, exp);
    end
  endtask

  // Reference model: registers and busy bits advance on each rising edge.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        for (int n = 0; n < 32; n++) begin
          m_regs[k][n] = 32'h0;
          m_busy[k][n] = 1'b0;
        end
      end else begin
        for (int j = 0; j < NWR; j++) begin
          int wa;
          wa = int'(wr_addr[j*AW +: AW]);
          if (wr_en[j] && wa != 0 && wa < nregs(k)) begin
            m_regs[k][wa] = wr_data[j*XLEN +: XLEN];
            m_busy[k][wa] = 1'b0;
          end
        end
        if (iss_valid && iss_rd != 5'd0 && int'(iss_rd) < nregs(k))
          m_busy[k][int'(iss_rd)] = 1'b1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    #2;
    if (check_en) begin
      logic [31:0] eb0;
      logic [23:0] eb1;
      for (int i = 0; i < NRD; i++) begin
        chk("rd_data0", i, rd_data0[i*XLEN +: XLEN], exp_data(0, i));
        chk("rd_busy0", i, rd_busy0[i], exp_busy(0, i));
        chk("rd_data1", i, rd_data1[i*XLEN +: XLEN], exp_data(1, i));
        chk("rd_busy1", i, rd_busy1[i], exp_busy(1, i));
      end
      for (int n = 0; n < NR0; n++) begin
        eb0[n] = m_busy[0][n];
        chk("dbg_regs0", n, dbg0[n*XLEN +: XLEN], m_regs[0][n]);
      end
      for (int n = 0; n < NR1; n++) begin
        eb1[n] = m_busy[1][n];
        chk("dbg_regs1", n, dbg1[n*XLEN +: XLEN], m_regs[1][n]);
      end
      chk("busy_vec0", 0, busy_vec0, eb0);
      chk("busy_vec1", 0, busy_vec1, eb1);
    end
  end

  task automatic idle();
    reset     = 1'b1;
    wr_en     = '0;
    iss_valid = 1'b0;
  endtask

  task automatic set_wr(input int j, input int a, input logic [31:0] d);
    wr_en[j]                = 1'b1;
    wr_addr[j*AW +: AW]     = 5'(a);
    wr_data[j*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int i, input int a);
    rd_addr[i*AW +: AW] = 5'(a);
  endtask

  task automatic issue(input int a);
    iss_valid = 1'b1;
    iss_rd    = 5'(a);
  endtask

  initial begin
    reset = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; iss_valid = 1'b0; iss_rd = '0;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    idle();
    #1;
    chk("reset_rd_data0", 0, rd_data0, 64'h0);
    chk("reset_rd_busy0", 0, rd_busy0, 64'h0);
    chk("reset_busy_vec0", 0, busy_vec0, 64'h0);
    chk("reset_dbg0_zero", 0, 64'(dbg0 == '0), 64'h1);

    // x5 write, forwarded on instance 0 only, then stored in both
    @(negedge clk); idle(); set_wr(0, 5, 32'hDEADBEEF); set_rd(0, 5); #1;
    chk("fwd_x5_byp1", 0, rd_data0[31:0], 64'hDEADBEEF);
    chk("fwd_x5_byp0", 0, rd_data1[31:0], 64'h0);
    @(negedge clk); idle(); #1;
    chk("read_x5_0", 0, rd_data0[31:0], 64'hDEADBEEF);
    chk("read_x5_1", 0, rd_data1[31:0], 64'hDEADBEEF);

    // x0 ignores writes, also while being forwarded
    @(negedge clk); idle(); set_wr(0, 0, 32'h1234); set_rd(0, 0); set_rd(1, 0); #1;
    chk("fwd_x0", 0, rd_data0, 64'h0);
    @(negedge clk); idle(); #1;
    chk("read_x0", 0, rd_data0[31:0], 64'h0);

    // x7: issue with write in same cycle keeps busy; then forwarded write
    @(negedge clk); idle(); set_wr(0, 7, 32'h11111111); issue(7);
    @(negedge clk); idle(); set_wr(1, 7, 32'hA5A5A5A5); set_rd(1, 7); #1;
    chk("busy_x7_set", 7, busy_vec0[7], 64'h1);
    chk("fwd_x7_data", 1, rd_data0[63:32], 64'hA5A5A5A5);
    chk("fwd_x7_busy", 1, rd_busy0[1], 64'h0);
    chk("nofwd_x7_data", 1, rd_data1[63:32], 64'h11111111);
    chk("nofwd_x7_busy", 1, rd_busy1[1], 64'h1);
    @(negedge clk); idle(); #1;
    chk("busy_x7_clr", 7, busy_vec0[7], 64'h0);
    chk("read_x7_1", 1, rd_data1[63:32], 64'hA5A5A5A5);

    // both ports write x3: higher port wins
    @(negedge clk); idle(); set_wr(0, 3, 32'h11); set_wr(1, 3, 32'h22); set_rd(0, 3); #1;
    chk("fwd_x3_prio", 0, rd_data0[31:0], 64'h22);
    @(negedge clk); idle(); #1;
    chk("store_x3_0", 3, dbg0[96 +: 32], 64'h22);
    chk("store_x3_1", 3, dbg1[96 +: 32], 64'h22);

    // x9 scoreboard sequence
    @(negedge clk); idle(); issue(9); set_rd(0, 9);
    @(negedge clk); idle(); #1;
    chk("busy_x9_vec", 9, busy_vec0[9], 64'h1);
    chk("busy_x9_rd0", 0, rd_busy0[0], 64'h1);
    chk("busy_x9_rd1", 0, rd_busy1[0], 64'h1);
    @(negedge clk); idle(); set_wr(0, 9, 32'h99); issue(9);
    @(negedge clk); idle(); #1;
    chk("busy_x9_keep", 9, busy_vec0[9], 64'h1);
    @(negedge clk); idle(); set_wr(0, 9, 32'h77);
    @(negedge clk); idle(); #1;
    chk("busy_x9_clr0", 9, busy_vec0[9], 64'h0);
    chk("busy_x9_clr1", 9, busy_vec1[9], 64'h0);

    // load x1..x31 with n, mark x12 busy, then reset alongside a write and an issue
    for (int n = 1; n < 32; n += 2) begin
      @(negedge clk); idle(); set_wr(0, n, 32'(n));
      if (n + 1 < 32) set_wr(1, n + 1, 32'(n + 1));
    end
    @(negedge clk); idle(); issue(12); set_rd(0, 12);
    @(negedge clk); idle(); #1;
    chk("load_x31", 31, dbg0[31*32 +: 32], 64'd31);
    chk("busy_x12", 0, rd_busy0[0], 64'h1);
    @(negedge clk); idle(); reset = 1'b0; set_wr(0, 4, 32'hFFFF); issue(4);
    @(negedge clk); idle(); #1;
    chk("rst_dbg0_zero", 0, 64'(dbg0 == '0), 64'h1);
    chk("rst_dbg1_zero", 0, 64'(dbg1 == '0), 64'h1);
    chk("rst_busy_vec0", 0, busy_vec0, 64'h0);
    chk("rst_rd_busy0", 0, rd_busy0[0], 64'h0);

    // issue x0 ignored; address 30 out of range on the 24-register instance
    @(negedge clk); idle(); issue(0); set_wr(0, 30, 32'hBAD0BAD0); set_rd(1, 30); #1;
    chk("oor_rd_data1", 1, rd_data1[63:32], 64'h0);
    chk("oor_rd_busy1", 1, rd_busy1[1], 64'h0);
    @(negedge clk); idle(); issue(30); #1;
    chk("iss_x0_vec0", 0, busy_vec0, 64'h0);
    @(negedge clk); idle(); #1;
    chk("iss_x30_vec0", 0, busy_vec0, 64'h4000_0000);
    chk("iss_x30_vec1", 0, busy_vec1, 64'h0);
    chk("oor_x30_data1", 1, rd_data1[63:32], 64'h0);
    chk("oor_x30_busy1", 1, rd_busy1[1], 64'h0);
    chk("x30_data0", 1, rd_data0[63:32], 64'hBAD0BAD0);

    // randomized traffic, biased so reads often hit same-cycle writes
    repeat (1500) begin
      @(negedge clk);
      reset     = ($urandom_range(63) != 0);
      wr_en     = 2'($urandom_range(3));
      wr_addr   = 10'($urandom);
      wr_data   = {$urandom, $urandom};
      iss_valid = ($urandom_range(2) != 0);
      iss_rd    = 5'($urandom);
      rd_addr   = 10'($urandom);
      if ($urandom_range(1) == 0) rd_addr[4:0] = wr_addr[4:0];
      if ($urandom_range(3) == 0) rd_addr[9:5] = wr_addr[9:5];
    end

    @(negedge clk); idle();
    @(negedge clk);
    #3;
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
